overlay_rd_arbiter: RTL and testbench

Two-requester arbiter that shares one MIG read port (command FIFO plus read-data FIFO) between two overlay DRAM readers, such as two stacked overlay planes. Each requester sees a private MIG-style read port. The arbiter does three things:
- serialises commands round-robin;
- records the owner and length of every issued burst in an in-order tag FIFO;
- steers returned words only to the owning requester.

It sits between the overlay readers and the single MIG user read port.

---
 rtl/overlay_rd_arbiter_if.sv | 45 ++++
 rtl/overlay_rd_arbiter.sv | 248 ++++++++++++++++++++++++
 tb/tb_overlay_rd_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/overlay_rd_arbiter_if.sv
// overlay_rd_arbiter_if
// MIG-style read port: command strobe/burst, read-data FIFO and flush.
interface overlay_rd_arbiter_if #(
   parameter int ADDR_WIDTH = 26,
   parameter int BL_WIDTH   = 9
);

   logic                  cmd_en;
   logic [BL_WIDTH-1:0]   cmd_bl;
   logic [ADDR_WIDTH-1:0] cmd_byte_addr;
   logic                  cmd_full;
   logic                  cmd_empty;
   logic                  rd_en;
   logic [31:0]           rd_data;
   logic                  rd_empty;
   logic [BL_WIDTH-1:0]   rd_count;
   logic                  rd_reset;

   modport master (
      output cmd_en,
      output cmd_bl,
      output cmd_byte_addr,
      output rd_en,
      output rd_reset,
      input  cmd_full,
      input  cmd_empty,
      input  rd_data,
      input  rd_empty,
      input  rd_count
   );

   modport slave (
      input  cmd_en,
      input  cmd_bl,
      input  cmd_byte_addr,
      input  rd_en,
      input  rd_reset,
      output cmd_full,
      output cmd_empty,
      output rd_data,
      output rd_empty,
      output rd_count
   );

endinterface

// File: rtl/overlay_rd_arbiter.sv
// overlay_rd_arbiter
// Shares one MIG read port between two readers; in-order tags steer data.
module overlay_rd_arbiter #(
   parameter int ADDR_WIDTH = 26,
   parameter int BL_WIDTH   = 9,
   parameter int TAG_DEPTH  = 4
) (
   input  logic                clk,
   input  logic                resetb,
   overlay_rd_arbiter_if.slave  p0,
   overlay_rd_arbiter_if.slave  p1,
   overlay_rd_arbiter_if.master mig
);

   localparam int PW = $clog2(TAG_DEPTH);
   localparam int OW = PW + 1;
   localparam int LW = BL_WIDTH + 1;

   localparam logic [PW:0]   PTR_ONE = 1;
   localparam logic [LW-1:0] LEN_ONE = 1;

   typedef struct packed {
      logic          owner;
      logic [LW-1:0] len;
   } tag_t;

   // requester ports gathered into indexable form
   logic [1:0]            cmd_en;
   logic [1:0]            rd_en;
   logic [1:0]            rd_reset;
   logic [BL_WIDTH-1:0]   cmd_bl   [2];
   logic [ADDR_WIDTH-1:0] cmd_addr [2];

   assign cmd_en      = {p1.cmd_en, p0.cmd_en};
   assign rd_en       = {p1.rd_en, p0.rd_en};
   assign rd_reset    = {p1.rd_reset, p0.rd_reset};
   assign cmd_bl[0]   = p0.cmd_bl;
   assign cmd_bl[1]   = p1.cmd_bl;
   assign cmd_addr[0] = p0.cmd_byte_addr;
   assign cmd_addr[1] = p1.cmd_byte_addr;

   // pending slots
   logic [1:0]            slot_v;
   logic [BL_WIDTH-1:0]   slot_bl   [2];
   logic [ADDR_WIDTH-1:0] slot_addr [2];

   // grant
   logic [1:0] req;
   logic [1:0] gnt;
   logic       grant;
   logic       pick;
   logic       last_grant;
   tag_t       new_tag;

   // MIG command register
   logic                  mcmd_en;
   logic [BL_WIDTH-1:0]   mcmd_bl;
   logic [ADDR_WIDTH-1:0] mcmd_addr;

   // tag FIFO
   tag_t        tags [TAG_DEPTH];
   logic [PW:0] wr_ptr;
   logic [PW:0] rd_ptr;
   logic        tag_empty;
   logic        tag_full;
   tag_t        head;

   // steering
   logic                live;
   logic                disc_h;
   logic                serve;
   logic                deliver;
   logic                drop;
   logic                own_en;
   logic                pop;
   logic                tag_pop;
   logic [LW-1:0]       mig_cnt_w;
   logic [BL_WIDTH-1:0] cnt;

   // outstanding bookkeeping
   logic [OW-1:0] out_q  [2];
   logic [OW-1:0] out_nx [2];
   logic [1:0]    discard;
   logic [1:0]    disc_nx;
   logic [1:0]    dec;

   logic unused;
   assign unused = mig.cmd_empty;

   assign tag_empty = (wr_ptr == rd_ptr);
   assign tag_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                      (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign head      = tags[rd_ptr[PW-1:0]];

   // round-robin pick among slots not being flushed this cycle
   always_comb begin
      req   = slot_v & ~rd_reset;
      grant = 1'b0;
      pick  = 1'b0;
      if (!mig.cmd_full && !tag_full) begin
         case (req)
            2'b01: begin
               grant = 1'b1;
               pick  = 1'b0;
            end
            2'b10: begin
               grant = 1'b1;
               pick  = 1'b1;
            end
            2'b11: begin
               grant = 1'b1;
               pick  = ~last_grant;
            end
            default: begin
               grant = 1'b0;
               pick  = 1'b0;
            end
         endcase
      end
      gnt = 2'b00;
      if (grant) begin
         gnt[pick] = 1'b1;
      end
      new_tag.owner = pick;
      new_tag.len   = LW'(slot_bl[pick]) + LEN_ONE;
   end

   // pending slot load/clear; a strobe into an occupied slot is dropped
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         slot_v <= 2'b00;
         for (int n = 0; n < 2; n++) begin
            slot_bl[n]   <= '0;
            slot_addr[n] <= '0;
         end
      end else begin
         for (int n = 0; n < 2; n++) begin
            if (rd_reset[n] || gnt[n]) begin
               slot_v[n] <= 1'b0;
            end else if (cmd_en[n] && !slot_v[n]) begin
               slot_v[n]    <= 1'b1;
               slot_bl[n]   <= cmd_bl[n];
               slot_addr[n] <= cmd_addr[n];
            end
         end
      end
   end

   // registered MIG command and round-robin memory
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         mcmd_en    <= 1'b0;
         mcmd_bl    <= '0;
         mcmd_addr  <= '0;
         last_grant <= 1'b1;
      end else begin
         mcmd_en <= grant;
         if (grant) begin
            mcmd_bl    <= slot_bl[pick];
            mcmd_addr  <= slot_addr[pick];
            last_grant <= pick;
         end
      end
   end

   // head tag decides who may see MIG data; discarded owners drain silently
   always_comb begin
      live      = !tag_empty;
      disc_h    = head.owner ? discard[1] : discard[0];
      own_en    = head.owner ? rd_en[1] : rd_en[0];
      serve     = live && !disc_h;
      deliver   = serve && !mig.rd_empty;
      drop      = live && disc_h && !mig.rd_empty;
      pop       = drop || (deliver && own_en);
      tag_pop   = pop && (head.len == LEN_ONE);
      mig_cnt_w = {1'b0, mig.rd_count};
      if (mig_cnt_w < head.len) begin
         cnt = mig.rd_count;
      end else begin
         cnt = head.len[BL_WIDTH-1:0];
      end
      dec = 2'b00;
      if (tag_pop) begin
         dec[head.owner] = 1'b1;
      end
   end

   // tag FIFO: push on grant, count down head, retire on last word
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < TAG_DEPTH; i++) begin
            tags[i] <= '0;
         end
      end else begin
         if (grant) begin
            tags[wr_ptr[PW-1:0]] <= new_tag;
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (tag_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end else if (pop) begin
            tags[rd_ptr[PW-1:0]].len <= head.len - LEN_ONE;
         end
      end
   end

   // next outstanding count and discard state per requester
   always_comb begin
      for (int n = 0; n < 2; n++) begin
         out_nx[n]  = out_q[n] + OW'(gnt[n]) - OW'(dec[n]);
         disc_nx[n] = (discard[n] | rd_reset[n]) && (out_nx[n] != '0);
      end
   end

   // outstanding counters and discard flags
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         out_q[0] <= '0;
         out_q[1] <= '0;
         discard  <= 2'b00;
      end else begin
         out_q[0] <= out_nx[0];
         out_q[1] <= out_nx[1];
         discard  <= disc_nx;
      end
   end

   assign mig.cmd_en        = mcmd_en;
   assign mig.cmd_bl        = mcmd_bl;
   assign mig.cmd_byte_addr = mcmd_addr;
   assign mig.rd_en         = pop;
   assign mig.rd_reset      = 1'b0;

   assign p0.cmd_full  = slot_v[0];
   assign p1.cmd_full  = slot_v[1];
   assign p0.cmd_empty = !slot_v[0] && (out_q[0] == '0);
   assign p1.cmd_empty = !slot_v[1] && (out_q[1] == '0);

   assign p0.rd_data  = mig.rd_data;
   assign p1.rd_data  = mig.rd_data;
   assign p0.rd_empty = !(deliver && !head.owner);
   assign p1.rd_empty = !(deliver && head.owner);
   assign p0.rd_count = (serve && !head.owner) ? cnt : '0;
   assign p1.rd_count = (serve && head.owner) ? cnt : '0;

endmodule

// File: tb/tb_overlay_rd_arbiter.sv
// tb_overlay_rd_arbiter
// Directed stimulus, expected-response queues drained by a negedge monitor.
module tb_overlay_rd_arbiter;

   localparam int AW = 26;
   localparam int BW = 9;

   typedef struct packed {
      logic [BW-1:0] bl;
      logic [AW-1:0] addr;
   } cmd_t;

   logic clk = 1'b0;
   logic resetb;

   always #5 clk = ~clk;

   overlay_rd_arbiter_if #(.ADDR_WIDTH(AW), .BL_WIDTH(BW)) p0 ();
   overlay_rd_arbiter_if #(.ADDR_WIDTH(AW), .BL_WIDTH(BW)) p1 ();
   overlay_rd_arbiter_if #(.ADDR_WIDTH(AW), .BL_WIDTH(BW)) mig ();

   overlay_rd_arbiter #(
      .ADDR_WIDTH(AW),
      .BL_WIDTH  (BW),
      .TAG_DEPTH (4)
   ) dut (
      .clk   (clk),
      .resetb(resetb),
      .p0    (p0),
      .p1    (p1),
      .mig   (mig)
   );

   int vectors     = 0;
   int miscompares = 0;

   cmd_t        exp_cmd [$];
   logic [31:0] exp_d0  [$];
   logic [31:0] exp_d1  [$];
   logic [31:0] mq      [$];

   logic          hold = 1'b0;
   logic          m_empty;
   logic [31:0]   m_data;
   logic [BW-1:0] m_count;
   int            mig_pops = 0;
   int            cmd_seen = 0;
   int            leak1    = 0;

   function automatic logic [31:0] word(input logic [AW-1:0] a, input int i);
      logic [15:0] lo;
      lo = 16'(i);
      return {a[15:0], lo};
   endfunction

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // MIG model: data FIFO fed by issued commands, optionally withheld
   assign mig.rd_empty  = m_empty | hold;
   assign mig.rd_count  = hold ? '0 : m_count;
   assign mig.rd_data   = m_data;
   assign mig.cmd_empty = m_empty;

   always @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         mq.delete();
         m_empty <= 1'b1;
         m_count <= '0;
         m_data  <= '0;
      end else begin
         if (mig.rd_en) begin
            if (mq.size() > 0) mq.delete(0);
            mig_pops <= mig_pops + 1;
         end
         if (mig.cmd_en) begin
            for (int i = 0; i <= int'(mig.cmd_bl); i++) begin
               mq.push_back(word(mig.cmd_byte_addr, i));
            end
         end
         m_empty <= (mq.size() == 0);
         m_count <= (mq.size() > 511) ? 9'd511 : BW'(mq.size());
         m_data  <= (mq.size() > 0) ? mq[0] : 32'd0;
      end
   end

   // monitor: compare every presented command and every accepted word
   always @(negedge clk) begin
      if (resetb === 1'b1) begin
         if (!p1.rd_empty && exp_d1.size() == 0) leak1 <= leak1 + 1;
         if (mig.cmd_en) begin
            cmd_seen <= cmd_seen + 1;
            if (exp_cmd.size() == 0) begin
               check("cmd_unexpected", 64'd1, 64'd0);
            end else begin
               check("mig_cmd", 64'({mig.cmd_bl, mig.cmd_byte_addr}),
                     64'(exp_cmd[0]));
               exp_cmd.delete(0);
            end
         end
         if (p0.rd_en && !p0.rd_empty) begin
            if (exp_d0.size() == 0) begin
               check("p0_unexpected", 64'(p0.rd_data), 64'hdead);
            end else begin
               check("p0_data", 64'(p0.rd_data), 64'(exp_d0[0]));
               exp_d0.delete(0);
            end
         end
         if (p1.rd_en && !p1.rd_empty) begin
            if (exp_d1.size() == 0) begin
               check("p1_unexpected", 64'(p1.rd_data), 64'hdead);
            end else begin
               check("p1_data", 64'(p1.rd_data), 64'(exp_d1[0]));
               exp_d1.delete(0);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cmd(input int p, input logic en, input int bl,
                          input int a);
      if (p == 0) begin
         p0.cmd_en        = en;
         p0.cmd_bl        = BW'(bl);
         p0.cmd_byte_addr = AW'(a);
      end else begin
         p1.cmd_en        = en;
         p1.cmd_bl        = BW'(bl);
         p1.cmd_byte_addr = AW'(a);
      end
   endtask

   task automatic push_data(input int p, input int bl, input int a);
      for (int i = 0; i <= bl; i++) begin
         if (p == 0) exp_d0.push_back(word(AW'(a), i));
         else exp_d1.push_back(word(AW'(a), i));
      end
   endtask

   task automatic push_cmd(input int bl, input int a);
      cmd_t c;
      c.bl   = BW'(bl);
      c.addr = AW'(a);
      exp_cmd.push_back(c);
   endtask

   task automatic issue(input int p, input int bl, input int a,
                        input logic want_data);
      int n;
      n = 0;
      while (((p == 0) ? p0.cmd_full : p1.cmd_full) && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) check("issue_timeout", 64'd1, 64'd0);
      push_cmd(bl, a);
      if (want_data) push_data(p, bl, a);
      set_cmd(p, 1'b1, bl, a);
      tick();
      set_cmd(p, 1'b0, 0, 0);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((exp_cmd.size() != 0 || exp_d0.size() != 0 ||
              exp_d1.size() != 0) && n < 300) begin
         tick();
         n++;
      end
      check(name, 64'(n < 300), 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got time limit expected finish");
      $fatal(1);
   end

   initial begin
      int base;
      int lbase;
      int pbase;
      int n;

      resetb = 1'b1;
      set_cmd(0, 1'b0, 0, 0);
      set_cmd(1, 1'b0, 0, 0);
      p0.rd_en    = 1'b1;
      p1.rd_en    = 1'b1;
      p0.rd_reset = 1'b0;
      p1.rd_reset = 1'b0;
      mig.cmd_full = 1'b0;
      #2 resetb = 1'b0;
      #10;
      check("rst_mig_cmd_en", 64'(mig.cmd_en), 64'd0);
      check("rst_mig_rd_en", 64'(mig.rd_en), 64'd0);
      check("rst_p0_cmd_empty", 64'(p0.cmd_empty), 64'd1);
      check("rst_p1_cmd_empty", 64'(p1.cmd_empty), 64'd1);
      check("rst_p0_rd_empty", 64'(p0.rd_empty), 64'd1);
      check("rst_p1_rd_empty", 64'(p1.rd_empty), 64'd1);
      check("rst_p0_cmd_full", 64'(p0.cmd_full), 64'd0);
      check("rst_p0_rd_count", 64'(p0.rd_count), 64'd0);
      tick();
      resetb = 1'b1;
      tick();

      // tie: port 0 wins first, port 1 next cycle
      push_cmd(3, 'h200);
      push_cmd(3, 'h300);
      push_data(0, 3, 'h200);
      push_data(1, 3, 'h300);
      set_cmd(0, 1'b1, 3, 'h200);
      set_cmd(1, 1'b1, 3, 'h300);
      tick();
      set_cmd(0, 1'b0, 0, 0);
      set_cmd(1, 1'b0, 0, 0);
      check("tie_lat", 64'(mig.cmd_en), 64'd0);
      tick();
      check("tie_grant_a", 64'(mig.cmd_en), 64'd1);
      tick();
      check("tie_grant_b", 64'(mig.cmd_en), 64'd1);
      wait_idle("tie_idle");

      // single requester with two-clock command latency
      lbase = leak1;
      issue(0, 7, 'h100, 1'b1);
      check("single_lat_k", 64'(mig.cmd_en), 64'd0);
      tick();
      check("single_lat_k1", 64'(mig.cmd_en), 64'd1);
      check("single_p0_busy", 64'(p0.cmd_empty), 64'd0);
      wait_idle("single_idle");
      check("single_p0_cmd_empty", 64'(p0.cmd_empty), 64'd1);
      check("single_p1_leak", 64'(leak1 - lbase), 64'd0);

      // backpressure: last grant was port 0, so port 1 goes first
      mig.cmd_full = 1'b1;
      push_cmd(1, 'h500);
      push_cmd(1, 'h400);
      push_data(0, 1, 'h400);
      push_data(1, 1, 'h500);
      set_cmd(0, 1'b1, 1, 'h400);
      set_cmd(1, 1'b1, 1, 'h500);
      tick();
      set_cmd(0, 1'b0, 0, 0);
      set_cmd(1, 1'b0, 0, 0);
      base = cmd_seen;
      repeat (10) tick();
      check("bp_no_cmd", 64'(cmd_seen - base), 64'd0);
      check("bp_p0_full", 64'(p0.cmd_full), 64'd1);
      check("bp_p1_full", 64'(p1.cmd_full), 64'd1);
      mig.cmd_full = 1'b0;
      tick();
      check("bp_rel_a", 64'(mig.cmd_en), 64'd1);
      tick();
      check("bp_rel_b", 64'(mig.cmd_en), 64'd1);
      wait_idle("bp_idle");

      // tag FIFO full: four issued, fifth waits for the first pop
      hold = 1'b1;
      base = cmd_seen;
      for (int i = 0; i < 5; i++) begin
         issue(0, 0, 'h1000 + i * 16, 1'b1);
      end
      repeat (6) tick();
      check("tagfull_issued", 64'(cmd_seen - base), 64'd4);
      check("tagfull_slot", 64'(p0.cmd_full), 64'd1);
      hold = 1'b0;
      tick();
      hold = 1'b1;
      check("tagfull_wait", 64'(mig.cmd_en), 64'd0);
      tick();
      check("tagfull_release", 64'(mig.cmd_en), 64'd1);
      hold = 1'b0;
      wait_idle("tagfull_idle");

      // flush: two port 1 bursts are drained, port 0 data survives
      hold = 1'b1;
      issue(1, 3, 'h2000, 1'b0);
      issue(1, 3, 'h2100, 1'b0);
      issue(0, 1, 'h2200, 1'b1);
      n = 0;
      while (exp_cmd.size() != 0 && n < 30) begin
         tick();
         n++;
      end
      check("flush_cmds_out", 64'(exp_cmd.size()), 64'd0);
      check("flush_p1_busy", 64'(p1.cmd_empty), 64'd0);
      lbase = leak1;
      pbase = mig_pops;
      p1.rd_reset = 1'b1;
      tick();
      p1.rd_reset = 1'b0;
      hold = 1'b0;
      wait_idle("flush_idle");
      repeat (2) tick();
      check("flush_pops", 64'(mig_pops - pbase), 64'd10);
      check("flush_p1_leak", 64'(leak1 - lbase), 64'd0);
      check("flush_p1_cmd_empty", 64'(p1.cmd_empty), 64'd1);
      check("flush_p0_cmd_empty", 64'(p0.cmd_empty), 64'd1);

      // asynchronous reset with three words left
      p0.rd_en = 1'b0;
      issue(0, 7, 'h3000, 1'b1);
      n = 0;
      while (p0.rd_count != 9'd8 && n < 20) begin
         tick();
         n++;
      end
      check("ar_count8", 64'(p0.rd_count), 64'd8);
      p0.rd_en = 1'b1;
      repeat (5) tick();
      check("ar_count3", 64'(p0.rd_count), 64'd3);
      check("ar_pre_rd_en", 64'(mig.rd_en), 64'd1);
      #1 resetb = 1'b0;
      #1;
      check("ar_rd_en", 64'(mig.rd_en), 64'd0);
      check("ar_p0_rd_empty", 64'(p0.rd_empty), 64'd1);
      check("ar_p0_cmd_empty", 64'(p0.cmd_empty), 64'd1);
      check("ar_p0_rd_count", 64'(p0.rd_count), 64'd0);
      exp_d0.delete();
      tick();
      tick();
      resetb = 1'b1;
      tick();
      issue(0, 3, 'h3100, 1'b1);
      wait_idle("ar_idle");
      tick();
      check("ar_p0_cmd_empty_end", 64'(p0.cmd_empty), 64'd1);

      check("end_cmd_queue", 64'(exp_cmd.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
